// File: rtl/arvi_bus_pkg.sv
// Shared bus widths and arbiter state encoding for the round-robin bus arbiter.
package arvi_bus_pkg;

   localparam int BUS_DATA_W = 32;
   localparam int BUS_BE_W   = 4;
   localparam int BUS_OP_W   = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_LOCK  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping around the request vector.
module rr_picker #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [ID_W-1:0]  i_ptr,
   output logic             o_found,
   output logic [ID_W-1:0]  o_idx
);

   logic [2*N_REQ-1:0] w_dbl;

   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                input int unsigned     off);
      logic [ID_W:0] sum;
      sum = {1'b0, base} + off[ID_W:0];
      if (sum >= N_REQ[ID_W:0]) sum = sum - N_REQ[ID_W:0];
      return sum[ID_W-1:0];
   endfunction

   // Doubled vector shifted by the pointer puts the highest-priority request at bit 0
   assign w_dbl = {i_req, i_req} >> i_ptr;

   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (w_dbl[i]) begin
            o_found = 1'b1;
            o_idx   = wrap_add(i_ptr, i);
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter muxing N_REQ requesters onto one downstream bus.
// Optional atomic bus locking is compiled in with the ARB_LOCK_EN macro.
module bus_arbiter_rr
   import arvi_bus_pkg::*;
#(
   parameter  int N_REQ    = 4,
   parameter  int LOCK_MAX = 16,
   localparam int ID_W     = ($clog2(N_REQ) < 1) ? 1 : $clog2(N_REQ)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [N_REQ-1:0]          i_req_en,
   input  logic [N_REQ-1:0]          i_req_wr_en,
   input  logic [N_REQ*BUS_DATA_W-1:0] i_req_wr_data,
   input  logic [N_REQ*BUS_DATA_W-1:0] i_req_addr,
   input  logic [N_REQ*BUS_BE_W-1:0] i_req_byte_en,
   input  logic [N_REQ-1:0]          i_req_atomic,
   input  logic [N_REQ*BUS_OP_W-1:0] i_req_operation,
   output logic [N_REQ-1:0]          o_req_ack,
   output logic [BUS_DATA_W-1:0]     o_req_rd_data,
   output logic                      o_bus_en,
   output logic                      o_wr_en,
   output logic                      o_atomic,
   output logic [BUS_DATA_W-1:0]     o_wr_data,
   output logic [BUS_DATA_W-1:0]     o_addr,
   output logic [BUS_BE_W-1:0]       o_byte_en,
   output logic [BUS_OP_W-1:0]       o_operation,
   output logic [ID_W-1:0]           o_id,
   input  logic                      i_ack,
   input  logic [BUS_DATA_W-1:0]     i_rd_data
);

   if (N_REQ < 2 || N_REQ > 8 || LOCK_MAX < 1) begin : g_param_check
      $error("bus_arbiter_rr: N_REQ must be 2..8 and LOCK_MAX >= 1");
   end

   arb_state_t      r_state;
   arb_state_t      w_state_nxt;
   logic [ID_W-1:0] r_ptr;
   logic [ID_W-1:0] w_ptr_nxt;
   logic [ID_W-1:0] r_gnt;
   logic [ID_W-1:0] w_gnt_nxt;
   logic [ID_W-1:0] w_ptr_inc;
   logic [ID_W-1:0] w_pick;
   logic            w_found;
   logic            w_sel_req;
   logic            w_sel_atomic;
   logic            w_active;
   logic            w_ack;
   int              w_g;

`ifdef ARB_LOCK_EN
   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   logic [CNT_W-1:0] r_lock_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
`endif

   rr_picker #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_picker (
      .i_req   (i_req_en),
      .i_ptr   (r_ptr),
      .o_found (w_found),
      .o_idx   (w_pick)
   );

   assign w_g          = int'(r_gnt);
   assign w_sel_req    = i_req_en[r_gnt];
   assign w_sel_atomic = i_req_atomic[r_gnt];
   assign w_ptr_inc    = (r_gnt == ID_W'(N_REQ - 1)) ? '0 : r_gnt + 1'b1;

   // Bus is driven in GRANT, and in LOCK only while the holder is requesting
   assign w_active = i_rst && ((r_state == ST_GRANT) ||
                               ((r_state == ST_LOCK) && w_sel_req));
   assign w_ack    = w_active && w_sel_req && i_ack;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_gnt      <= '0;
`ifdef ARB_LOCK_EN
         r_lock_cnt <= '0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_ptr      <= w_ptr_nxt;
         r_gnt      <= w_gnt_nxt;
`ifdef ARB_LOCK_EN
         r_lock_cnt <= w_cnt_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_gnt_nxt   = r_gnt;
`ifdef ARB_LOCK_EN
      w_cnt_nxt   = r_lock_cnt;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_gnt_nxt   = w_pick;
               w_state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (w_ack) begin
`ifdef ARB_LOCK_EN
               if (w_sel_atomic) begin
                  w_state_nxt = ST_LOCK;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_ptr_nxt   = w_ptr_inc;
               end
`else
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = w_ptr_inc;
`endif
            end else if (!w_sel_req) begin
               w_state_nxt = ST_IDLE;
            end
         end
`ifdef ARB_LOCK_EN
         ST_LOCK: begin
            if (w_ack) begin
               w_cnt_nxt = '0;
               if (!w_sel_atomic) begin
                  w_state_nxt = ST_IDLE;
                  w_ptr_nxt   = w_ptr_inc;
               end
            end else if (!w_sel_req) begin
               // Holder has gone quiet: force release after LOCK_MAX idle cycles
               if (r_lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
                  w_state_nxt = ST_IDLE;
                  w_ptr_nxt   = w_ptr_inc;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_lock_cnt + 1'b1;
               end
            end
         end
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_req_ack     = '0;
      o_req_rd_data = '0;
      o_bus_en      = 1'b0;
      o_wr_en       = 1'b0;
      o_atomic      = 1'b0;
      o_wr_data     = '0;
      o_addr        = '0;
      o_byte_en     = '0;
      o_operation   = '0;
      o_id          = '0;
      if (w_active) begin
         o_bus_en    = w_sel_req && !i_ack;
         o_wr_en     = i_req_wr_en[r_gnt];
         o_atomic    = w_sel_atomic;
         o_wr_data   = i_req_wr_data[w_g*BUS_DATA_W +: BUS_DATA_W];
         o_addr      = i_req_addr[w_g*BUS_DATA_W +: BUS_DATA_W];
         o_byte_en   = i_req_byte_en[w_g*BUS_BE_W +: BUS_BE_W];
         o_operation = i_req_operation[w_g*BUS_OP_W +: BUS_OP_W];
         o_id        = r_gnt;
      end
      if (w_ack) begin
         o_req_ack[r_gnt] = 1'b1;
         o_req_rd_data    = i_rd_data;
      end
   end

endmodule
